bits_imem_responder: RTL and testbench

- Responder end of the instruction-fetch handshake used by the BITS decoder core (mem_req_b / mem_ack_b / instruction_word / instruction_byte_valid / done_reading_memory).
- Reads the hex-packed BITS transmission from a 32-bit single-port instruction SRAM and packs it into 128-bit words.
- Returns each word with a per-byte valid mask, one word per request.
- Flags end of stream once expectedBytes bytes have been delivered.

---
 rtl/bits_imem_pkg.sv | 31 +++
 rtl/bits_imem_packer.sv | 63 ++++++
 rtl/bits_imem_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_bits_imem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bits_imem_pkg.sv
// Shared types and helpers for the BITS instruction-memory responder.
package bits_imem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StLast = 2'd2,
        StAck  = 2'd3
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 16;
    localparam int unsigned BYTES_PER_BEAT = 4;

    // MSB-first mask with the top n of 16 bits set.
    function automatic logic [15:0] valid_mask(input logic [4:0] n);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            if (5'(i) < n) m[15-i] = 1'b1;
        end
        return m;
    endfunction

    // Number of 4-byte SRAM beats needed to cover n bytes.
    function automatic logic [2:0] beats(input logic [4:0] n);
        logic [5:0] t;
        t = {1'b0, n} + 6'(BYTES_PER_BEAT - 1);
        return t[4:2];
    endfunction

endpackage

// File: rtl/bits_imem_packer.sv
// Places successive 32-bit SRAM beats into 128-bit lanes, MSB-first, and masks
// off byte lanes beyond the transaction length.
module bits_imem_packer
    import bits_imem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         beat_valid_i,
    input  logic [31:0]  rdata_i,
    input  logic [4:0]   n_i,
    output logic [127:0] word_o
);

    logic [127:0] acc_q, acc_d;
    logic [127:0] placed;
    logic [127:0] byte_mask;
    logic [15:0]  mask;
    logic [3:0]   sel_q, sel_d;

    // Steer the current beat into the lane selected by the one-hot beat index.
    always_comb begin
        placed = '0;
        for (int i = 0; i < 4; i++) begin
            if (sel_q[3-i]) placed[127-32*i -: 32] = rdata_i;
        end
    end

    // Accumulate beats; clear wins so a fresh transaction never inherits stale lanes.
    always_comb begin
        acc_d = acc_q;
        sel_d = sel_q;
        if (clear_i) begin
            acc_d = '0;
            sel_d = 4'b1000;
        end else if (beat_valid_i) begin
            acc_d = acc_q | placed;
            sel_d = sel_q >> 1;
        end
    end

    // Expand the byte mask and merge the in-flight final beat into the output.
    always_comb begin
        mask = valid_mask(n_i);
        byte_mask = '0;
        for (int b = 0; b < 16; b++) begin
            byte_mask[8*b +: 8] = {8{mask[b]}};
        end
        word_o = (acc_q | (beat_valid_i ? placed : 128'd0)) & byte_mask;
    end

    // Accumulator and beat-index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            sel_q <= 4'b1000;
        end else begin
            acc_q <= acc_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/bits_imem_responder.sv
// Responder for the BITS core instruction-fetch handshake. Reads 32-bit SRAM
// beats, packs them into 128-bit words and acks one word per request.
// Optional macro BITS_IMEM_PREFETCH_EN adds a one-word prefetch holding buffer.
module bits_imem_responder
    import bits_imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned MEM_DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       expectedBytes,
    input  logic              mem_req_b,
    output logic              mem_ack_b,
    output logic [127:0]      instruction_word,
    output logic [15:0]       instruction_byte_valid,
    output logic              done_reading_memory,
    output logic              imem_ceb,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [MEM_DW-1:0] imem_rdata
);

    state_e             state_q, state_d;
    logic [15:0]        total_q, total_d, sent_q, sent_d;
    logic [ADDR_W-1:0]  wptr_q, wptr_d, addr_q, addr_d;
    logic [2:0]         left_q, left_d;
    logic [4:0]         n_q, n_d;
    logic               ceb_q, ceb_d, ack_b_q, ack_b_d, done_q, done_d;
    logic               rvalid_q, rvalid_d;
    logic [127:0]       word_q, word_d;
    logic [15:0]        valid_q, valid_d;

    logic [15:0]        rem, sent_sum;
    logic [4:0]         n_next;
    logic [2:0]         k_next;
    logic               launch, pk_clear;
    logic [127:0]       pk_word;

`ifdef BITS_IMEM_PREFETCH_EN
    logic [127:0]       buf_word_q, buf_word_d;
    logic [15:0]        buf_mask_q, buf_mask_d;
    logic               buf_full_q, buf_full_d;
`endif

    bits_imem_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pk_clear),
        .beat_valid_i (rvalid_q),
        .rdata_i      (imem_rdata),
        .n_i          (n_q),
        .word_o       (pk_word)
    );

    // Next-state logic: start overrides everything, otherwise walk IDLE/READ/LAST/ACK.
    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        sent_d   = sent_q;
        wptr_d   = wptr_q;
        addr_d   = addr_q;
        left_d   = left_q;
        n_d      = n_q;
        ceb_d    = ceb_q;
        ack_b_d  = 1'b1;
        word_d   = word_q;
        valid_d  = valid_q;
        done_d   = done_q;
        rvalid_d = ~ceb_q;
        pk_clear = 1'b0;
        launch   = 1'b0;
        rem      = total_q - sent_q;
        n_next   = (rem > 16'd16) ? 5'd16 : rem[4:0];
        k_next   = beats(n_next);
        sent_sum = sent_q + 16'(n_q);
`ifdef BITS_IMEM_PREFETCH_EN
        buf_word_d = buf_word_q;
        buf_mask_d = buf_mask_q;
        buf_full_d = buf_full_q;
`endif
        if (start) begin
            state_d = StIdle;
            ceb_d   = 1'b1;
            total_d = expectedBytes;
            sent_d  = '0;
            wptr_d  = '0;
            done_d  = (expectedBytes == 16'd0);
`ifdef BITS_IMEM_PREFETCH_EN
            buf_full_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
`ifdef BITS_IMEM_PREFETCH_EN
                    if (buf_full_q) begin
                        if (!mem_req_b) begin
                            ack_b_d    = 1'b0;
                            word_d     = buf_word_q;
                            valid_d    = buf_mask_q;
                            buf_full_d = 1'b0;
                            if (sent_q == total_q) done_d = 1'b1;
                            state_d    = StAck;
                        end
                    end else if (rem != 16'd0 || !mem_req_b) begin
                        // Refill whenever bytes remain; zero-length only on demand.
                        launch = 1'b1;
                    end
`else
                    launch = ~mem_req_b;
`endif
                    if (launch) begin
                        pk_clear = 1'b1;
                        n_d      = n_next;
                        addr_d   = wptr_q;
                        wptr_d   = wptr_q + ADDR_W'(k_next);
                        left_d   = k_next - 3'd1;
                        if (k_next == 3'd0) begin
                            // Nothing left: go through LAST so the empty ack keeps k+2 timing.
                            state_d = StLast;
                        end else begin
                            ceb_d   = 1'b0;
                            state_d = StRead;
                        end
                    end
                end
                StRead: begin
                    if (left_q == 3'd0) begin
                        ceb_d   = 1'b1;
                        state_d = StLast;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        left_d = left_q - 3'd1;
                    end
                end
                StLast: begin
                    sent_d = sent_sum;
`ifdef BITS_IMEM_PREFETCH_EN
                    if (!mem_req_b || n_q == 5'd0) begin
`endif
                        ack_b_d = 1'b0;
                        word_d  = pk_word;
                        valid_d = valid_mask(n_q);
                        if (sent_sum == total_q) done_d = 1'b1;
                        state_d = StAck;
`ifdef BITS_IMEM_PREFETCH_EN
                    end else begin
                        buf_word_d = pk_word;
                        buf_mask_d = valid_mask(n_q);
                        buf_full_d = 1'b1;
                        state_d    = StIdle;
                    end
`endif
                end
                StAck: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            total_q  <= '0;
            sent_q   <= '0;
            wptr_q   <= '0;
            addr_q   <= '0;
            left_q   <= '0;
            n_q      <= '0;
            ceb_q    <= 1'b1;
            ack_b_q  <= 1'b1;
            word_q   <= '0;
            valid_q  <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            sent_q   <= sent_d;
            wptr_q   <= wptr_d;
            addr_q   <= addr_d;
            left_q   <= left_d;
            n_q      <= n_d;
            ceb_q    <= ceb_d;
            ack_b_q  <= ack_b_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef BITS_IMEM_PREFETCH_EN
    // Prefetch holding buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_word_q <= '0;
            buf_mask_q <= '0;
            buf_full_q <= 1'b0;
        end else begin
            buf_word_q <= buf_word_d;
            buf_mask_q <= buf_mask_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

    assign mem_ack_b              = ack_b_q;
    assign instruction_word       = word_q;
    assign instruction_byte_valid = valid_q;
    assign done_reading_memory    = done_q;
    assign imem_ceb               = ceb_q;
    assign imem_addr              = addr_q;

endmodule

// File: tb/tb_bits_imem_responder.sv
// Directed, scoreboard-based bench for bits_imem_responder.
module tb_bits_imem_responder;

    localparam int unsigned ADDR_W = 14;
`ifdef BITS_IMEM_PREFETCH_EN
    localparam int LAT_PF = 1;
`else
    localparam int LAT_PF = 6;
`endif

    typedef struct packed {
        logic [127:0] w;
        logic [15:0]  v;
        logic         d;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       expectedBytes = '0;
    logic              mem_req_b = 1'b1;
    logic              mem_ack_b;
    logic [127:0]      instruction_word;
    logic [15:0]       instruction_byte_valid;
    logic              done_reading_memory;
    logic              imem_ceb;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = '0;

    logic [31:0]       mem [16];
    exp_t              sb [$];
    logic [13:0]       rd_log [$];
    int                rd_cyc [$];
    int                ack_cycles [$];
    int                cyc = 0;
    int                n_acks = 0;
    int                last_ack_cyc = 0;
    int                n_cmp = 0;
    int                n_bad = 0;
    exp_t              e;
    logic              have;

    bits_imem_responder #(.ADDR_W(ADDR_W), .MEM_DW(32)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .expectedBytes          (expectedBytes),
        .mem_req_b              (mem_req_b),
        .mem_ack_b              (mem_ack_b),
        .instruction_word       (instruction_word),
        .instruction_byte_valid (instruction_byte_valid),
        .done_reading_memory    (done_reading_memory),
        .imem_ceb               (imem_ceb),
        .imem_addr              (imem_addr),
        .imem_rdata             (imem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency.
    always @(posedge clk) if (!imem_ceb) imem_rdata <= mem[imem_addr[3:0]];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: log SRAM reads and score every ack against the queue.
    always @(negedge clk) begin
        if (!reset && !imem_ceb) begin
            rd_log.push_back(imem_addr);
            rd_cyc.push_back(cyc);
        end
        if (!reset && !mem_ack_b) begin
            n_acks++;
            last_ack_cyc = cyc;
            ack_cycles.push_back(cyc);
            have = (sb.size() != 0);
            chk("ack_expected", 128'(have), 128'(1));
            e = have ? sb.pop_front() : '0;
            chk("ack_word", instruction_word, e.w);
            chk("ack_valid", 128'(instruction_byte_valid), 128'(e.v));
            chk("ack_done", 128'(done_reading_memory), 128'(e.d));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] nb);
        expectedBytes = nb;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic logic [127:0] mkword(input int b);
        return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
    endfunction

    // One request: push expectation, lower req, wait (bounded) for the ack, raise req.
    task automatic req_once(input string tag, input logic [127:0] w, input logic [15:0] v,
                            input logic d, input int lat);
        int c0, n0;
        sb.push_back('{w: w, v: v, d: d});
        c0 = cyc;
        n0 = n_acks;
        mem_req_b = 1'b0;
        for (int i = 0; i < 30 && n_acks == n0; i++) @(posedge clk);
        #1;
        chk({tag, "_seen"}, 128'(n_acks != n0), 128'(1));
        chk({tag, "_lat"}, 128'(last_ack_cyc - c0), 128'(lat));
        mem_req_b = 1'b1;
    endtask

    initial begin
        int c0, n0;
        mem[0] = 32'hD2FE2800; mem[1] = 32'h11112222;
        mem[2] = 32'h33334444; mem[3] = 32'h55556666;
        mem[4] = 32'hA1A2A3A4; mem[5] = 32'hB1B2B3B4;
        for (int i = 6; i < 16; i++) mem[i] = 32'hC0DE0000 + 32'(i);

        // Reset values.
        tick(3);
        chk("rst_ack_b", 128'(mem_ack_b), 128'(1));
        chk("rst_ceb", 128'(imem_ceb), 128'(1));
        chk("rst_addr", 128'(imem_addr), 128'(0));
        chk("rst_word", instruction_word, 128'(0));
        chk("rst_valid", 128'(instruction_byte_valid), 128'(0));
        chk("rst_done", 128'(done_reading_memory), 128'(0));
        reset = 1'b0;
        tick(2);

        // 16-byte stream, single request.
        do_start(16);
        chk("t1_done_pre", 128'(done_reading_memory), 128'(0));
        rd_log.delete(); rd_cyc.delete();
        c0 = cyc;
        req_once("t1", 128'hD2FE2800111122223333444455556666, 16'hFFFF, 1'b1, 6);
`ifndef BITS_IMEM_PREFETCH_EN
        chk("t1_nreads", 128'(rd_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            chk("t1_addr", 128'(rd_log[i]), 128'(i));
            chk("t1_rdcyc", 128'(rd_cyc[i] - c0), 128'(i + 1));
        end
`endif

        // 21-byte stream: full word then a 5-byte tail.
        do_start(21);
        req_once("t2a", mkword(0), 16'hFFFF, 1'b0, 6);
        rd_log.delete();
        req_once("t2b", 128'hA1A2A3A4B10000000000000000000000, 16'hF800, 1'b1, 4);
`ifndef BITS_IMEM_PREFETCH_EN
        chk("t2_nreads", 128'(rd_log.size()), 128'(2));
        if (rd_log.size() == 2) begin
            chk("t2_addr0", 128'(rd_log[0]), 128'(4));
            chk("t2_addr1", 128'(rd_log[1]), 128'(5));
        end
`endif
        tick(3);
        chk("t2_hold_word", instruction_word, 128'hA1A2A3A4B10000000000000000000000);
        chk("t2_hold_valid", 128'(instruction_byte_valid), 128'(16'hF800));

        // Zero-length stream.
        do_start(0);
        chk("t3_done", 128'(done_reading_memory), 128'(1));
        rd_log.delete();
        req_once("t3", 128'(0), 16'h0000, 1'b1, 2);
        chk("t3_nreads", 128'(rd_log.size()), 128'(0));

        // start aborts a fetch in its second READ cycle.
        do_start(16);
        mem_req_b = 1'b0;
        tick(2);
        expectedBytes = 16;
        start = 1'b1;
        mem_req_b = 1'b1;
        tick(1);
        start = 1'b0;
        @(negedge clk);
        chk("t4_ceb_off", 128'(imem_ceb), 128'(1));
        n0 = n_acks;
        tick(8);
        chk("t4_no_ack", 128'(n_acks), 128'(n0));
        rd_log.delete();
        req_once("t4", mkword(0), 16'hFFFF, 1'b1, LAT_PF);
`ifndef BITS_IMEM_PREFETCH_EN
        chk("t4_first_addr", 128'(rd_log.size() > 0 ? rd_log[0] : 14'h3FFF), 128'(0));
`endif

        // Held request over a 48-byte stream, then two empty acks.
        do_start(48);
        for (int i = 0; i < 3; i++) sb.push_back('{w: mkword(4 * i), v: 16'hFFFF, d: (i == 2)});
        for (int i = 0; i < 2; i++) sb.push_back('{w: 128'(0), v: 16'h0000, d: 1'b1});
        ack_cycles.delete();
        c0 = cyc;
        n0 = n_acks;
        mem_req_b = 1'b0;
        for (int i = 0; i < 80 && n_acks < n0 + 5; i++) @(posedge clk);
        #1;
        mem_req_b = 1'b1;
        chk("t5_nacks", 128'(n_acks - n0), 128'(5));
`ifndef BITS_IMEM_PREFETCH_EN
        if (ack_cycles.size() == 5) begin
            chk("t5_lat0", 128'(ack_cycles[0] - c0), 128'(6));
            chk("t5_gap1", 128'(ack_cycles[1] - ack_cycles[0]), 128'(7));
            chk("t5_gap2", 128'(ack_cycles[2] - ack_cycles[1]), 128'(7));
            chk("t5_gap3", 128'(ack_cycles[3] - ack_cycles[2]), 128'(3));
            chk("t5_gap4", 128'(ack_cycles[4] - ack_cycles[3]), 128'(3));
        end
`endif
        rd_log.delete();
        n0 = n_acks;
        tick(10);
        chk("t5_idle_reads", 128'(rd_log.size()), 128'(0));
        chk("t5_idle_acks", 128'(n_acks), 128'(n0));
        sb.delete();

        // 32-byte stream, requests spaced apart.
        do_start(32);
        tick(10);
        req_once("t6a", mkword(0), 16'hFFFF, 1'b0, LAT_PF);
        tick(10);
        req_once("t6b", mkword(4), 16'hFFFF, 1'b1, LAT_PF);

        // Asynchronous reset in the middle of a fetch.
        do_start(16);
        mem_req_b = 1'b0;
        tick(2);
        n0 = n_acks;
        reset = 1'b1;
        #1;
        chk("t7_ack_b", 128'(mem_ack_b), 128'(1));
        chk("t7_ceb", 128'(imem_ceb), 128'(1));
        chk("t7_word", instruction_word, 128'(0));
        chk("t7_valid", 128'(instruction_byte_valid), 128'(0));
        chk("t7_done", 128'(done_reading_memory), 128'(0));
        mem_req_b = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
        chk("t7_no_ack", 128'(n_acks), 128'(n0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
